// File: rtl/alu_seq_if.sv
// alu_seq_if
//   Operand/result bundle for alu_seq.
//   Operand side : in_valid, in_ready, A, B, sel
//   Result side  : out_valid, out_ready, Y, Z, N, C, V
//   Status       : busy (high while a multiply is iterating)
//   modport slave  - the ALU (consumes operands, produces results)
//   modport master - the environment driving operands and taking results
interface alu_seq_if #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_A-1:0] A;
    logic [WIDTH_B-1:0] B;
    logic [1:0]         sel;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_A-1:0] Y;
    logic               Z;
    logic               N;
    logic               C;
    logic               V;
    logic               busy;

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, Y, Z, N, C, V, busy
    );

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, Y, Z, N, C, V, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
//   Sequential ALU: MUL (00, iterative shift-add, one bit of B per cycle),
//   SUB (01), AND (10), XOR (11) with Z/N/C/V flags, registered results and
//   valid/ready handshakes on both sides. One operation in flight.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_seq_if.slave: operands in, result + flags + busy out
module alu_seq #(
    parameter int WIDTH_A = 4,
    parameter int WIDTH_B = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    generate
        if (WIDTH_A < 2 || WIDTH_B < 1 || WIDTH_B > WIDTH_A) begin : g_bad_params
            $error("alu_seq: need WIDTH_A >= 2 and 1 <= WIDTH_B <= WIDTH_A");
        end
    endgenerate

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic [PW-1:0]      acc;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               mul_last;
    logic [WIDTH_A-1:0] b_ext;
    logic [WIDTH_A:0]   diff;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      mul_sum;
    logic [WIDTH_A-1:0] op_y;
    logic               op_c;
    logic               op_v;

    assign bus.in_ready = (state == S_IDLE);
    assign bus.busy     = (state == S_MUL_RUN);

    assign accept   = bus.in_valid && (state == S_IDLE);
    assign mul_last = (state == S_MUL_RUN) && (cnt == CW'(WIDTH_B - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_nx = (bus.sel == 2'b00) ? S_MUL_RUN : S_DONE;
                end
            end
            S_MUL_RUN: begin
                if (mul_last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Single-cycle ops work straight off the bus operands at the accept edge.
    always_comb begin
        b_ext = WIDTH_A'(bus.B);
        diff  = {1'b0, bus.A} - {1'b0, b_ext};
        op_y  = '0;
        op_c  = 1'b0;
        op_v  = 1'b0;
        case (bus.sel)
            2'b01: begin
                op_y = diff[WIDTH_A-1:0];
                op_c = diff[WIDTH_A];
                // Overflow only when operand signs differ and the result sign flips from A
                op_v = (bus.A[WIDTH_A-1] ^ b_ext[WIDTH_A-1]) &
                       (diff[WIDTH_A-1] ^ bus.A[WIDTH_A-1]);
            end
            2'b10:   op_y = bus.A & b_ext;
            2'b11:   op_y = bus.A ^ b_ext;
            default: op_y = '0;
        endcase
    end

    // One partial product per MUL_RUN cycle; the last one is folded straight
    // into Y so the result appears without an extra cycle.
    always_comb begin
        addend  = PW'(a_q) << cnt;
        mul_sum = acc + (b_q[cnt] ? addend : '0);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.Y         <= '0;
            bus.Z         <= 1'b0;
            bus.N         <= 1'b0;
            bus.C         <= 1'b0;
            bus.V         <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            a_q <= bus.A;
            b_q <= bus.B;
            acc <= '0;
            cnt <= '0;
            if (bus.sel != 2'b00) begin
                bus.Y         <= op_y;
                bus.Z         <= (op_y == '0);
                bus.N         <= op_y[WIDTH_A-1];
                bus.C         <= op_c;
                bus.V         <= op_v;
                bus.out_valid <= 1'b1;
            end
        end else if (state == S_MUL_RUN) begin
            acc <= mul_sum;
            if (mul_last) begin
                cnt           <= '0;
                bus.Y         <= mul_sum[WIDTH_A-1:0];
                bus.Z         <= (mul_sum[WIDTH_A-1:0] == '0);
                bus.N         <= mul_sum[WIDTH_A-1];
                bus.C         <= |mul_sum[PW-1:WIDTH_A];
                bus.V         <= |mul_sum[PW-1:WIDTH_A];
                bus.out_valid <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (state == S_DONE && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Self-checking bench for alu_seq (WIDTH_A=4, WIDTH_B=2): directed operations
//   with literal expectations plus a transaction-level reference model compared
//   against the DUT every cycle.
module tb_alu_seq;
    localparam int WA  = 4;
    localparam int WB  = 2;
    localparam int MOD = 1 << WA;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic checking;

    alu_seq_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus ();

    alu_seq #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of an op from plain integer arithmetic: {Y, Z, N, C, V}
    function automatic logic [7:0] model_res(input int a, input int b, input int s);
        int y, c, v, p, sa, sd;
        y = 0; c = 0; v = 0;
        case (s)
            0: begin
                p = a * b;
                y = p % MOD;
                c = (p >= MOD) ? 1 : 0;
                v = c;
            end
            1: begin
                y  = (a - b + MOD) % MOD;
                c  = (a < b) ? 1 : 0;
                sa = (a >= MOD / 2) ? a - MOD : a;
                sd = sa - b;
                v  = (sd < -(MOD / 2) || sd >= MOD / 2) ? 1 : 0;
            end
            2: y = a & b;
            default: y = a ^ b;
        endcase
        return {4'(y), (y == 0), (y >= MOD / 2), (c != 0), (v != 0)};
    endfunction

    // Reference model: tracks readiness, remaining multiply cycles and the
    // result currently presented.
    logic       m_ready;
    logic       m_valid;
    int         m_left;
    logic [7:0] m_res;
    logic [7:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_left  = 0;
            m_res   = '0;
            m_pend  = '0;
        end else if (m_ready && bus.in_valid) begin
            m_pend  = model_res(int'(bus.A), int'(bus.B), int'(bus.sel));
            m_ready = 1'b0;
            if (bus.sel == 2'b00) begin
                m_left = WB;
            end else begin
                m_res   = m_pend;
                m_valid = 1'b1;
            end
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_res   = m_pend;
                m_valid = 1'b1;
            end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] exp_v;
        if (checking) begin
            act   = {bus.in_ready, bus.out_valid, bus.busy, bus.Y, bus.Z, bus.N, bus.C, bus.V};
            exp_v = {m_ready, m_valid, (m_left > 0), m_res};
            n_cmp = n_cmp + 1;
            if (act !== exp_v) begin
                n_bad = n_bad + 1;
                $display("FAIL model_cycle t=%0t: rdy/vld/busy/Y/ZNCV actual=%b required=%b",
                         $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s t=%0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one op, check latency / busy cycles / result against literals,
    // optionally hold off out_ready for 'hold' cycles with in_valid asserted.
    task automatic run_op(input logic [3:0] a, input logic [1:0] b, input logic [1:0] s,
                          input logic [3:0] ey, input logic [3:0] ef,
                          input int elat, input int ebusy, input int hold);
        int lat;
        int nb;
        wait_ready();
        bus.A         = a;
        bus.B         = b;
        bus.sel       = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.sel      = ~s;
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) nb++;
        end while (!bus.out_valid && lat < 20);
        check("latency", 32'(lat), 32'(elat));
        check("busy_cycles", 32'(nb), 32'(ebusy));
        check("Y", 32'(bus.Y), 32'(ey));
        check("ZNCV", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'(ef));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                @(negedge clk);
                check("hold_stable", 32'({bus.out_valid, bus.in_ready, bus.Y, bus.Z, bus.N, bus.C, bus.V}),
                      32'({1'b1, 1'b0, ey, ef}));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("released", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        checking      = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.Y, bus.Z, bus.N, bus.C, bus.V}),
              32'b100_0000_0000);
        rst_n    = 1'b1;
        checking = 1'b1;

        //      A        B      sel    Y        ZNCV     lat busy hold
        run_op(4'b0101, 2'b01, 2'b00, 4'b0101, 4'b0000, 3, 2, 0);
        run_op(4'b1111, 2'b11, 2'b00, 4'b1101, 4'b0111, 3, 2, 0);
        run_op(4'b1111, 2'b00, 2'b00, 4'b0000, 4'b1000, 3, 2, 0);
        run_op(4'b0101, 2'b01, 2'b01, 4'b0100, 4'b0000, 1, 0, 0);
        run_op(4'b0000, 2'b11, 2'b01, 4'b1101, 4'b0110, 1, 0, 0);
        run_op(4'b1000, 2'b01, 2'b01, 4'b0111, 4'b0001, 1, 0, 0);
        run_op(4'b0000, 2'b00, 2'b10, 4'b0000, 4'b1000, 1, 0, 0);
        run_op(4'b1111, 2'b11, 2'b11, 4'b1100, 4'b0100, 1, 0, 5);
        run_op(4'b0110, 2'b10, 2'b00, 4'b1100, 4'b0100, 3, 2, 5);

        // Reset pulse in the middle of a multiply
        wait_ready();
        bus.A        = 4'b1111;
        bus.B        = 2'b11;
        bus.sel      = 2'b00;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.Y, bus.Z, bus.N, bus.C, bus.V}),
              32'b100_0000_0000);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_ready", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);

        run_op(4'b1010, 2'b10, 2'b10, 4'b0010, 4'b0000, 1, 0, 0);
        run_op(4'b0011, 2'b11, 2'b00, 4'b1001, 4'b0100, 3, 2, 0);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
